// File: rtl/mnist_img_streamer.sv
// mnist_img_streamer: buffers one image, streams it as LANES-pixel beats, then
// waits (bounded by TIMEOUT cycles) for a classifier result and captures it.
// Latency: first beat on the cycle after start; start-to-done = BEATS+2 with
// m_ready=1 and an immediate result.
// Backpressure: valid/ready on m_*; beat held stable while m_ready=0.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data      pixel-buffer write port (IDLE only)
//   start                      one-cycle request to stream the buffered image
//   m_data/m_valid/m_ready     pixel beat stream, lane 0 in the LSBs
//   res_valid/res_pred/res_conf classifier result strobe (WAIT_RES only)
//   busy, done, timed_out      status; done is a one-cycle pulse
//   pred_out, conf_out         last captured result
module mnist_img_streamer #(
    parameter int IMG_PIX = 784,
    parameter int PIX_W   = 1,
    parameter int LANES   = 1,
    parameter int TIMEOUT = 20000,
    localparam int BEATS  = (IMG_PIX + LANES - 1) / LANES,
    localparam int AW     = (IMG_PIX > 1) ? $clog2(IMG_PIX) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [PIX_W-1:0]         wr_data,
    input  logic                     start,
    output logic [LANES*PIX_W-1:0]   m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    input  logic                     res_valid,
    input  logic [3:0]               res_pred,
    input  logic [7:0]               res_conf,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               pred_out,
    output logic [7:0]               conf_out,
    output logic                     timed_out
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [AW:0]   PIX_LIM   = (AW + 1)'(IMG_PIX);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_RES,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [BW-1:0]            beat_q, beat_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [3:0]               pred_q, pred_d;
    logic [7:0]               conf_q, conf_d;
    logic                     to_q, to_d;

    // Pixel buffer: deliberately outside reset so an image survives rst_n.
    logic [PIX_W-1:0]         pix_mem [IMG_PIX];
    logic [LANES*PIX_W-1:0]   beat_dat;
    int                       idx;

    always_ff @(posedge clk) begin
        if (rst_n && state_q == IDLE && wr_en && ({1'b0, wr_addr} < PIX_LIM)) begin
            pix_mem[wr_addr] <= wr_data;
        end
    end

    // Gather the current beat; lanes past the end of the image read as zero.
    always_comb begin
        beat_dat = '0;
        idx      = 0;
        for (int j = 0; j < LANES; j++) begin
            idx = int'(beat_q) * LANES + j;
            if (idx < IMG_PIX) begin
                beat_dat[j*PIX_W +: PIX_W] = pix_mem[idx[AW-1:0]];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        pred_d  = pred_q;
        conf_d  = conf_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    beat_d  = '0;
                    to_d    = 1'b0;
                end
            end
            STREAM: begin
                if (m_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = WAIT_RES;
                        cnt_d   = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            WAIT_RES: begin
                cnt_d = cnt_q + 1'b1;
                // A result arriving on the timeout cycle still takes priority.
                if (res_valid) begin
                    state_d = DONE;
                    pred_d  = res_pred;
                    conf_d  = res_conf;
                    to_d    = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    to_d    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            cnt_q   <= '0;
            pred_q  <= '0;
            conf_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            pred_q  <= pred_d;
            conf_q  <= conf_d;
            to_q    <= to_d;
        end
    end

    assign m_valid   = (state_q == STREAM);
    assign m_data    = m_valid ? beat_dat : '0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign pred_out  = pred_q;
    assign conf_out  = conf_q;
    assign timed_out = to_q;

endmodule

// File: tb/tb_mnist_img_streamer.sv
// Testbench for mnist_img_streamer: 20-pixel 4-bit image, 8 lanes (3 beats,
// last beat partly empty), TIMEOUT=16. Stimulus pushes expected beats/results
// into queues; a monitor process compares them as the DUT presents outputs.
module tb_mnist_img_streamer;

    localparam int IMG_PIX = 20;
    localparam int PIX_W   = 4;
    localparam int LANES   = 8;
    localparam int TIMEOUT = 16;
    localparam int BEATS   = 3;
    localparam int AW      = 5;
    localparam int DW      = LANES * PIX_W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [PIX_W-1:0] wr_data;
    logic            start;
    logic [DW-1:0]   m_data;
    logic            m_valid;
    logic            m_ready;
    logic            res_valid;
    logic [3:0]      res_pred;
    logic [7:0]      res_conf;
    logic            busy;
    logic            done;
    logic [3:0]      pred_out;
    logic [7:0]      conf_out;
    logic            timed_out;

    mnist_img_streamer #(
        .IMG_PIX (IMG_PIX),
        .PIX_W   (PIX_W),
        .LANES   (LANES),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .res_valid (res_valid),
        .res_pred  (res_pred),
        .res_conf  (res_conf),
        .busy      (busy),
        .done      (done),
        .pred_out  (pred_out),
        .conf_out  (conf_out),
        .timed_out (timed_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] p;
        logic [7:0] c;
        logic       to;
        int         cyc;
    } res_t;

    logic [PIX_W-1:0] img [IMG_PIX];
    logic [DW-1:0]    exp_q [$];
    res_t             res_q [$];
    int               n_vec = 0;
    int               n_bad = 0;
    bit               mon_en = 1'b0;
    logic [3:0]       mdl_p = '0;
    logic [7:0]       mdl_c = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] beat_of(input int k);
        logic [DW-1:0] b;
        b = '0;
        for (int j = 0; j < LANES; j++) begin
            if (k * LANES + j < IMG_PIX) b[j*PIX_W +: PIX_W] = img[k*LANES+j];
        end
        return b;
    endfunction

    task automatic load_image();
        for (int i = 0; i < IMG_PIX; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = img[i];
        end
        // Out-of-range writes must not disturb anything.
        @(negedge clk); wr_addr = 5'd20; wr_data = 4'hF;
        @(negedge clk); wr_addr = 5'd31; wr_data = 4'hF;
        @(negedge clk); wr_en = 1'b0;
    endtask

    // One image run. rnd: random m_ready; give/dly: result dly cycles after
    // WAIT_RES entry; inject: illegal start/write/result during STREAM.
    task automatic run(input bit rnd, input bit give, input int dly,
                       input logic [3:0] p, input logic [7:0] c,
                       input bit inject, input bit autopush);
        int n, guard;
        bit in_wait;
        if (autopush) for (int k = 0; k < BEATS; k++) exp_q.push_back(beat_of(k));
        @(negedge clk);
        start = 1'b1;
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        n = cyc;
        res_q.push_back('{give ? p : mdl_p, give ? c : mdl_c, !give,
                          rnd ? -1 : (give ? n + BEATS + 2 + dly : n + BEATS + 1 + TIMEOUT)});
        if (give) begin mdl_p = p; mdl_c = c; end
        in_wait = 1'b0;
        guard = 0;
        while (!in_wait && guard < 200) begin
            @(negedge clk);
            guard++;
            start = 1'b0; wr_en = 1'b0; res_valid = 1'b0;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (guard == 1) chk("busy_stream", busy, 1);
            if (inject && guard == 1) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = ~img[0];
                res_valid = 1'b1; res_pred = 4'hF; res_conf = 8'hFF;
            end
            in_wait = busy && !m_valid && !done;
        end
        chk("reach_wait", in_wait, 1);
        if (give) begin
            repeat (dly) @(negedge clk);
            res_valid = 1'b1; res_pred = p; res_conf = c;
            @(negedge clk);
            res_valid = 1'b0;
        end
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("return_idle", busy, 0);
        @(negedge clk);
        chk("timed_out_hold", timed_out, !give);
        chk("pred_hold", pred_out, mdl_p);
        m_ready = 1'b1;
    endtask

    // Monitor: compares presented beats and done pulses against the queues.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_beat: got %0h expected none (cycle %0d)", m_data, cyc);
                end else begin
                    chk("beat_data", m_data, exp_q[0]);
                    if (m_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("data_zero_when_invalid", m_data, 0);
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("pred_out", pred_out, r.p);
                    chk("conf_out", conf_out, r.c);
                    chk("timed_out", timed_out, r.to);
                    if (r.cyc >= 0) chk("done_cycle", cyc, r.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        m_ready = 1'b1; res_valid = 1'b0; res_pred = '0; res_conf = '0;
        for (int i = 0; i < IMG_PIX; i++) img[i] = 4'(i * 5 + 3);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_done", done, 0);
        chk("rst_timed_out", timed_out, 0);
        chk("rst_pred", pred_out, 0);
        chk("rst_conf", conf_out, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        load_image();
        // Hand-computed beats for img[i] = (5i+3) mod 16; beat 2 has 4 empty lanes.
        exp_q.push_back(32'h61C7_2D83);
        exp_q.push_back(32'hE94F_A50B);
        exp_q.push_back(32'h0000_2D83);
        run(0, 1, 0, 4'd7, 8'd200, 0, 0);       // immediate result: done at start+5
        run(0, 1, 3, 4'd3, 8'h55, 0, 1);        // delayed result
        run(0, 0, 0, 4'd0, 8'h00, 0, 1);        // timeout, previous result kept
        run(0, 1, 1, 4'd9, 8'h21, 1, 1);        // illegal inputs during STREAM ignored
        run(0, 1, 15, 4'd5, 8'h99, 0, 1);       // result on the timeout cycle wins

        for (int i = 0; i < IMG_PIX; i++) img[i] = 4'($urandom);
        load_image();
        run(1, 1, 2, 4'd2, 8'h42, 0, 1);        // random backpressure
        run(1, 1, 0, 4'd8, 8'h17, 0, 1);

        // Reset mid-stream while beat 2 is stalled, then re-stream without reload.
        for (int k = 0; k < BEATS; k++) exp_q.push_back(beat_of(k));
        @(negedge clk); start = 1'b1; m_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); m_ready = 1'b0; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; m_ready = 1'b1;
        exp_q.delete();
        mdl_p = '0; mdl_c = '0;
        chk("midrst_busy", busy, 0);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_pred", pred_out, 0);
        chk("midrst_conf", conf_out, 0);
        chk("midrst_timed_out", timed_out, 0);
        run(0, 1, 0, 4'd6, 8'h66, 0, 1);

        repeat (3) @(negedge clk);
        chk("beats_left", exp_q.size(), 0);
        chk("results_left", res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
